// File: rtl/sw_edge_irq_pio.sv
// rtl/sw_edge_irq_pio.sv - debounced switch input port with edge capture and level interrupt
//
// Purpose:
//   Samples WIDTH asynchronous switch inputs through a two-flop synchronizer,
//   debounces each bit with a per-bit stability counter, detects edges on the
//   debounced value and latches them into a sticky edge_capture register.
//   A level interrupt is raised while any captured bit is enabled in irq_mask.
//
// Parameters:
//   WIDTH            number of input bits (1..32)
//   EDGE_MODE        0 rising, 1 falling, 2 any edge
//   DEBOUNCE_CYCLES  consecutive differing cycles before the debounced bit moves; 0 = no debounce
//   BIT_CLEAR        1 = edge_capture is write-1-to-clear per bit, 0 = any write clears all bits
//
// Ports:
//   clk         sole clock, rising edge
//   reset       synchronous, active-high reset
//   address     0 debounced data, 1 synchronized raw data, 2 irq_mask, 3 edge_capture
//   chipselect  slave access qualifier (writes only)
//   write_n     active-low write strobe
//   writedata   write data, bits [WIDTH-1:0] used
//   in_port     asynchronous switch inputs
//   readdata    registered read data, zero-extended above WIDTH
//   irq         high while any masked capture bit is set

module sw_edge_irq_pio #(
  parameter int WIDTH           = 18,
  parameter int EDGE_MODE       = 0,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BIT_CLEAR       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_d;
  logic [WIDTH-1:0] detect;
  logic [WIDTH-1:0] clr_bits;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] wdata;
  logic             wr_en;

  // Bits of writedata above WIDTH carry no meaning for this port.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, writedata};

  assign wdata = writedata[WIDTH-1:0];
  assign wr_en = chipselect & ~write_n;

  // Two-flop synchronizer; sync2 is the raw value software sees at address 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
      always_ff @(posedge clk) begin
        if (reset) begin
          deb <= '0;
        end else begin
          deb <= sync2;
        end
      end
    end else begin : g_debounce
      localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] cnt [WIDTH];

      // The counter only runs while sync2 disagrees with the debounced bit;
      // any agreeing cycle restarts it, so a glitch shorter than
      // DEBOUNCE_CYCLES never reaches the debounced value.
      always_ff @(posedge clk) begin
        if (reset) begin
          deb <= '0;
          for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
          end
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (sync2[i] != deb[i]) begin
              if (cnt[i] == CNT_LAST) begin
                deb[i] <= sync2[i];
                cnt[i] <= '0;
              end else begin
                cnt[i] <= cnt[i] + CW'(1);
              end
            end else begin
              cnt[i] <= '0;
            end
          end
        end
      end
    end
  endgenerate

  // One-cycle delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_d <= '0;
    end else begin
      deb_d <= deb;
    end
  end

  always_comb begin
    detect = '0;
    case (EDGE_MODE)
      0:       detect = deb & ~deb_d;
      1:       detect = ~deb & deb_d;
      default: detect = deb ^ deb_d;
    endcase
  end

  always_comb begin
    clr_bits = '0;
    if (wr_en && (address == 2'd3)) begin
      clr_bits = (BIT_CLEAR != 0) ? wdata : '1;
    end
  end

  // Detect is OR-ed in after the clear so a same-cycle event is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= (edge_capture & ~clr_bits) | detect;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask <= '0;
    end else if (wr_en && (address == 2'd2)) begin
      irq_mask <= wdata;
    end
  end

  // Read mux is registered every cycle regardless of chipselect.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      case (address)
        2'd0:    readdata <= 32'(deb);
        2'd1:    readdata <= 32'(sync2);
        2'd2:    readdata <= 32'(irq_mask);
        default: readdata <= 32'(edge_capture);
      endcase
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_sw_edge_irq_pio.sv
// tb/tb_sw_edge_irq_pio.sv - self-checking bench for sw_edge_irq_pio

module tb_sw_edge_irq_pio;

  localparam int W = 18;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port0, in_port1, in_port2;
  logic [31:0]   rd0, rd1, rd2;
  logic          irq0, irq1, irq2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  always #5 clk = ~clk;

  // Rising edge, write-1-to-clear
  sw_edge_irq_pio #(.WIDTH(W), .EDGE_MODE(0), .DEBOUNCE_CYCLES(4), .BIT_CLEAR(1)) u_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port0),
    .readdata(rd0), .irq(irq0));

  // Any edge, write-1-to-clear
  sw_edge_irq_pio #(.WIDTH(W), .EDGE_MODE(2), .DEBOUNCE_CYCLES(4), .BIT_CLEAR(1)) u_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port1),
    .readdata(rd1), .irq(irq1));

  // Falling edge, any write clears all
  sw_edge_irq_pio #(.WIDTH(W), .EDGE_MODE(1), .DEBOUNCE_CYCLES(4), .BIT_CLEAR(0)) u_fall (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port2),
    .readdata(rd2), .irq(irq2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  // Expected value is queued as the address is presented and checked when
  // the registered read data appears one cycle later.
  task automatic rd(input int inst, input logic [1:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] obs;
    logic [31:0] e;
    string       t;
    address = a;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    step();
    obs = (inst == 0) ? rd0 : (inst == 1) ? rd1 : rd2;
    e   = exp_q.pop_front();
    t   = tag_q.pop_front();
    chk(t, obs, e);
  endtask

  task automatic chk_irq(input int inst, input logic exp, input string tag);
    logic obs;
    obs = (inst == 0) ? irq0 : (inst == 1) ? irq1 : irq2;
    chk(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port0   = '0;
    in_port1   = '0;
    in_port2   = '0;

    // Reset state
    steps(3);
    chk_irq(0, 1'b0, "reset_irq");
    chk("reset_readdata", rd0, 32'h0);
    reset = 1'b0;
    rd(0, 2'd0, 32'h0, "rst_data");
    rd(0, 2'd1, 32'h0, "rst_raw");
    rd(0, 2'd2, 32'h0, "rst_mask");
    rd(0, 2'd3, 32'h0, "rst_cap");

    // Any-edge and falling-edge instances
    wr(2'd2, 32'h1);
    in_port1[0] = 1'b1;
    in_port2[0] = 1'b1;
    steps(8);
    rd(1, 2'd3, 32'h1, "any_rise_cap");
    rd(2, 2'd3, 32'h0, "fall_rise_nocap");
    chk_irq(1, 1'b1, "any_rise_irq");
    chk_irq(2, 1'b0, "fall_rise_noirq");
    wr(2'd3, 32'h1);
    rd(1, 2'd3, 32'h0, "any_clear1");
    in_port1[0] = 1'b0;
    in_port2[0] = 1'b0;
    steps(8);
    rd(1, 2'd3, 32'h1, "any_fall_cap");
    rd(2, 2'd3, 32'h1, "fall_fall_cap");
    chk_irq(2, 1'b1, "fall_irq");
    wr(2'd3, 32'h2);
    rd(1, 2'd3, 32'h1, "any_w1c_other_bit");
    rd(2, 2'd3, 32'h0, "fall_clear_all");
    wr(2'd3, 32'h1);
    rd(1, 2'd3, 32'h0, "any_clear2");
    chk_irq(1, 1'b0, "any_irq_cleared");

    // Exact latency of a debounced rising edge on bit 3
    wr(2'd2, 32'h8);
    rd(0, 2'd2, 32'h8, "mask_0x8");
    in_port0[3] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk_irq(0, (k == 7), $sformatf("latency_irq_c%0d", k));
    end
    rd(0, 2'd3, 32'h8, "cap_bit3");
    rd(0, 2'd0, 32'h8, "data_bit3");
    rd(0, 2'd1, 32'h8, "raw_bit3");

    // Three-cycle glitch on bit 5 is filtered
    in_port0[5] = 1'b1;
    steps(3);
    in_port0[5] = 1'b0;
    steps(10);
    rd(0, 2'd0, 32'h8, "glitch_data");
    rd(0, 2'd3, 32'h8, "glitch_cap");

    // Write-1-to-clear leaves other bits alone
    in_port0[0] = 1'b1;
    steps(8);
    rd(0, 2'd3, 32'h9, "cap_0x9");
    wr(2'd3, 32'h1);
    rd(0, 2'd3, 32'h8, "w1c_bit0");
    chk_irq(0, 1'b1, "w1c_irq");

    // Writes to data registers ignored; upper writedata bits dropped
    wr(2'd0, 32'hFFFF_FFFF);
    rd(0, 2'd0, 32'h9, "wr_addr0_ignored");
    wr(2'd1, 32'hFFFF_FFFF);
    rd(0, 2'd1, 32'h9, "wr_addr1_ignored");
    wr(2'd2, 32'hFFFF_FFFF);
    rd(0, 2'd2, 32'h0003_FFFF, "mask_upper_dropped");
    wr(2'd2, 32'h0);
    chk_irq(0, 1'b0, "mask_off_irq");
    wr(2'd2, 32'h8);
    chk_irq(0, 1'b1, "mask_on_irq");

    // Clear and new detect on bit 0 in the same cycle
    in_port0[0] = 1'b0;
    steps(10);
    in_port0[0] = 1'b1;
    steps(6);
    wr(2'd3, 32'h1);
    rd(0, 2'd3, 32'h9, "clear_vs_detect");

    // Reset with everything captured and enabled
    in_port0 = 18'h3FFFF;
    steps(9);
    wr(2'd2, 32'h3FFFF);
    rd(0, 2'd3, 32'h3FFFF, "cap_all");
    chk_irq(0, 1'b1, "irq_all");
    reset = 1'b1;
    step();
    chk_irq(0, 1'b0, "reset_mid_irq");
    chk("reset_mid_readdata", rd0, 32'h0);
    rd(0, 2'd3, 32'h0, "reset_mid_cap");
    rd(0, 2'd2, 32'h0, "reset_mid_mask");

    // Input held high across reset release is a rising edge
    reset = 1'b0;
    wr(2'd2, 32'h3FFFF);
    for (int k = 2; k <= 7; k++) begin
      step();
      chk_irq(0, (k == 7), $sformatf("post_reset_irq_c%0d", k));
    end
    rd(0, 2'd3, 32'h3FFFF, "post_reset_cap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
